// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the registered ALU control sequencer: ALUOp codes,
// ALUCtl codes, FSM states and default multi-cycle latencies.
package alu_ctl_pkg;

    localparam logic [1:0] OP_LS = 2'b00;
    localparam logic [1:0] OP_BR = 2'b01;
    localparam logic [1:0] OP_R  = 2'b10;
    localparam logic [1:0] OP_I  = 2'b11;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_XOR = 4'b0011;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_MUL = 4'b1000;
    localparam logic [3:0] CTL_DIV = 4'b1001;
    localparam logic [3:0] CTL_REM = 4'b1010;
    localparam logic [3:0] CTL_ILL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_MULTI = 2'b10
    } state_t;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 16;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of (ALUOp, FuncCode, is_muldiv) into an ALU control
// code, an illegal flag and a multi-cycle flag. Illegal decodes yield CTL_ILL.
module alu_ctl_decode
    import alu_ctl_pkg::*;
#(
    parameter int OP_W   = 2,
    parameter int FUNC_W = 4,
    parameter int CTL_W  = 4
) (
    input  logic [OP_W-1:0]   alu_op,
    input  logic [FUNC_W-1:0] func_code,
    input  logic              is_muldiv,
    output logic [CTL_W-1:0]  ctl,
    output logic              illegal,
    output logic              multi
);

    logic [FUNC_W-1:0] func_eff;

    always_comb begin
        ctl      = CTL_ADD;
        illegal  = 1'b0;
        multi    = 1'b0;
        func_eff = func_code;
        if (is_muldiv) begin
            if (alu_op != OP_R) begin
                illegal = 1'b1;
            end else begin
                case (func_code)
                    4'b0000: begin ctl = CTL_MUL; multi = 1'b1; end
                    4'b0100: begin ctl = CTL_DIV; multi = 1'b1; end
                    4'b0110: begin ctl = CTL_REM; multi = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
        end else begin
            case (alu_op)
                OP_LS:   ctl = CTL_ADD;
                OP_BR:   ctl = CTL_SUB;
                default: begin
                    // I-type has no funct7 distinction, so the SUB bit is dropped
                    if (alu_op == OP_I) func_eff[FUNC_W-1] = 1'b0;
                    case (func_eff)
                        4'b0000: ctl = CTL_ADD;
                        4'b1000: ctl = CTL_SUB;
                        4'b0111: ctl = CTL_AND;
                        4'b0110: ctl = CTL_OR;
                        4'b0100: ctl = CTL_XOR;
                        default: illegal = 1'b1;
                    endcase
                end
            endcase
        end
        if (illegal) ctl = CTL_ILL;
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control with multi-cycle mul/div sequencing.
// Optional feature macro: ALU_CTL_ILLEGAL_TRAP_EN (illegal flag + saturating count).
module alu_control_seq
    import alu_ctl_pkg::*;
#(
    parameter int OP_W       = 2,
    parameter int FUNC_W     = 4,
    parameter int CTL_W      = 4,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   ALUOp,
    input  logic [FUNC_W-1:0] FuncCode,
    input  logic              is_muldiv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  ALUCtl,
    output logic              busy
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
    ,
    output logic              illegal,
    output logic [7:0]        illegal_cnt
`endif
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTL_W-1:0]   ctl_q, ctl_d;
    logic [CTL_W-1:0]   pend_q, pend_d;
    logic [CTL_W-1:0]   dec_ctl, sel_ctl;
    logic               dec_illegal, dec_multi;
    logic               accept;

    alu_ctl_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W), .CTL_W(CTL_W)) u_decode (
        .alu_op    (ALUOp),
        .func_code (FuncCode),
        .is_muldiv (is_muldiv),
        .ctl       (dec_ctl),
        .illegal   (dec_illegal),
        .multi     (dec_multi)
    );

`ifdef ALU_CTL_ILLEGAL_TRAP_EN
    assign sel_ctl = dec_ctl;
`else
    assign sel_ctl = dec_illegal ? CTL_W'(CTL_ADD) : dec_ctl;
`endif

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MULTI);
    assign ALUCtl    = ctl_q;

    // Next state; a HOLD that is drained and refilled in the same cycle stays full
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) state_d = ST_IDLE;
                if (accept) begin
                    if (dec_multi) begin
                        state_d = ST_MULTI;
                        pend_d  = sel_ctl;
                        cnt_d   = (sel_ctl == CTL_W'(CTL_MUL)) ? MUL_LOAD : DIV_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        ctl_d   = sel_ctl;
                    end
                end
            end
            ST_MULTI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    ctl_d   = pend_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctl_q   <= CTL_W'(CTL_ADD);
            pend_q  <= CTL_W'(CTL_ADD);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            pend_q  <= pend_d;
        end
    end

`ifdef ALU_CTL_ILLEGAL_TRAP_EN
    // Illegal decodes never go multi-cycle, so the flag only loads on single-cycle accepts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal     <= 1'b0;
            illegal_cnt <= 8'd0;
        end else if (accept && !dec_multi) begin
            illegal <= dec_illegal;
            if (dec_illegal && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
        end else if ((state_q == ST_MULTI) && (cnt_q == '0)) begin
            illegal <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq (default and MUL_CYCLES=1 instances).
module tb_alu_control_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [1:0] ALUOp;
    logic [3:0] FuncCode;
    logic       is_muldiv;
    logic       out_ready;

    logic       in_ready, out_valid, busy;
    logic [3:0] ALUCtl;
    logic       in_ready1, out_valid1, busy1;
    logic [3:0] ALUCtl1;
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
    logic       illegal, illegal1;
    logic [7:0] illegal_cnt, illegal_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    alu_control_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .FuncCode   (FuncCode),
        .is_muldiv  (is_muldiv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUCtl     (ALUCtl),
        .busy       (busy)
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
`endif
    );

    alu_control_seq #(.MUL_CYCLES(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .ALUOp      (ALUOp),
        .FuncCode   (FuncCode),
        .is_muldiv  (is_muldiv),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .ALUCtl     (ALUCtl1),
        .busy       (busy1)
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal1),
        .illegal_cnt(illegal_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] fc,
                                 input logic md, input logic ordy);
        in_valid  = v;
        ALUOp     = op;
        FuncCode  = fc;
        is_muldiv = md;
        out_ready = ordy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t1Func [4] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
    logic [3:0] t1Exp  [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

    logic [1:0] t4Op   [5] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [3:0] t4Func [5] = '{4'b1000, 4'b1111, 4'b1111, 4'b0001, 4'b0100};
    logic       t4Md   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t4Ill  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
    logic [3:0] t4Exp  [5] = '{4'b0010, 4'b0000, 4'b1111, 4'b1111, 4'b0011};
`else
    logic [3:0] t4Exp  [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0011};
`endif

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ctl", ALUCtl, 4'b0010);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
        checkOutput("rst_illegal", illegal, 1'b0);
        checkOutput("rst_illegal_cnt", illegal_cnt, 8'd0);
`endif
        reset = 1'b0;

        $display("[TB] R-type back-to-back");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b10, t1Func[i], 1'b0, 1'b1);
            checkOutput("t1_in_ready", in_ready, 1'b1);
            stepCycle();
            checkOutput("t1_ctl", ALUCtl, t1Exp[i]);
            checkOutput("t1_valid", out_valid, 1'b1);
        end
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t1_drain_valid", out_valid, 1'b0);

        $display("[TB] branch held under backpressure");
        applyStimulus(1'b1, 2'b01, 4'b1011, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t2_ctl", ALUCtl, 4'b0110);
        checkOutput("t2_valid", out_valid, 1'b1);
        applyStimulus(1'b1, 2'b00, 4'b0111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_in_ready", in_ready, 1'b0);
            stepCycle();
            checkOutput("t2_hold_ctl", ALUCtl, 4'b0110);
            checkOutput("t2_hold_valid", out_valid, 1'b1);
        end
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t2_release_valid", out_valid, 1'b0);
        checkOutput("t2_release_ctl", ALUCtl, 4'b0110);

        $display("[TB] DIV sequencing");
        applyStimulus(1'b1, 2'b10, 4'b0100, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b10, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t3_busy", busy, 1'b1);
            checkOutput("t3_in_ready", in_ready, 1'b0);
            checkOutput("t3_valid", out_valid, 1'b0);
            stepCycle();
        end
        checkOutput("t3_done_busy", busy, 1'b0);
        checkOutput("t3_done_valid", out_valid, 1'b1);
        checkOutput("t3_done_ctl", ALUCtl, 4'b1001);
        stepCycle();
        checkOutput("t3_held_ctl", ALUCtl, 4'b1001);
        checkOutput("t3_held_valid", out_valid, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t3_drain_valid", out_valid, 1'b0);

        $display("[TB] I-type masking and illegal decodes");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, t4Op[i], t4Func[i], t4Md[i], 1'b1);
            stepCycle();
            checkOutput("t4_ctl", ALUCtl, t4Exp[i]);
            checkOutput("t4_valid", out_valid, 1'b1);
            checkOutput("t4_busy", busy, 1'b0);
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
            checkOutput("t4_illegal", illegal, t4Ill[i]);
`else
            checkOutput("t4_illegal_is_add", ALUCtl == 4'b0010, t4Ill[i] | (t4Exp[i] == 4'b0010));
`endif
        end
`ifdef ALU_CTL_ILLEGAL_TRAP_EN
        checkOutput("t4_illegal_cnt", illegal_cnt, 8'd2);
`endif
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t4_drain_valid", out_valid, 1'b0);

        $display("[TB] reset during DIV");
        applyStimulus(1'b1, 2'b10, 4'b0100, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5_busy_pre", busy, 1'b1);
            stepCycle();
        end
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_valid", out_valid, 1'b0);
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_ctl", ALUCtl, 4'b0010);
        checkOutput("t5_rst_in_ready", in_ready, 1'b1);
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("t5_no_output", out_valid, 1'b0);
            checkOutput("t5_no_busy", busy, 1'b0);
        end

        $display("[TB] single-cycle MUL build");
        applyStimulus(1'b1, 2'b10, 4'b0000, 1'b1, 1'b1);
        checkOutput("t6_in_ready_mul", in_ready1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
        checkOutput("t6_busy", busy1, 1'b1);
        checkOutput("t6_in_ready_busy", in_ready1, 1'b0);
        checkOutput("t6_valid_busy", out_valid1, 1'b0);
        stepCycle();
        checkOutput("t6_mul_ctl", ALUCtl1, 4'b1000);
        checkOutput("t6_mul_valid", out_valid1, 1'b1);
        checkOutput("t6_mul_busy", busy1, 1'b0);
        checkOutput("t6_in_ready_hold", in_ready1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
        checkOutput("t6_add_ctl", ALUCtl1, 4'b0010);
        checkOutput("t6_add_valid", out_valid1, 1'b1);
        stepCycle();
        checkOutput("t6_drain_valid", out_valid1, 1'b0);
        stepCycle();
        checkOutput("t6_no_dup", out_valid1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
